// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver with selectable bit order, valid/ready output and sticky overrun.
// Optional even-parity trailer bit and parity_err output enabled by SIPO_DESERIALIZER_PARITY_EN.
module sipo_deserializer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             serial_in,
   input  logic             serial_valid,
   input  logic             lsb_first,
   input  logic             out_ready,
   input  logic             overrun_clr,
   output logic [WIDTH-1:0] parallel_out,
   output logic             out_valid,
   output logic             busy,
   output logic             overrun
`ifdef SIPO_DESERIALIZER_PARITY_EN
   ,
   output logic             parity_err
`endif
);

`ifdef SIPO_DESERIALIZER_PARITY_EN
   localparam int NB = WIDTH + 1;
`else
   localparam int NB = WIDTH;
`endif
   localparam int CW = $clog2(NB + 1);

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             dir;

   logic             dir_eff;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] word;
   logic             shift_en;
   logic             done;
   logic             load;
   logic             drop;
`ifdef SIPO_DESERIALIZER_PARITY_EN
   logic             perr;
`endif

   always_comb begin
      // Direction is taken live from lsb_first only on the first bit of a word.
      dir_eff = (state == IDLE) ? lsb_first : dir;
      shifted = dir_eff ? {serial_in, sreg[WIDTH-1:1]} : {sreg[WIDTH-2:0], serial_in};
      done    = serial_valid && (cnt == CW'(NB - 1));
`ifdef SIPO_DESERIALIZER_PARITY_EN
      // The trailing parity bit is checked but never enters the shift register.
      shift_en = (cnt != CW'(WIDTH));
      word     = sreg;
      perr     = ^{sreg, serial_in};
`else
      shift_en = 1'b1;
      word     = shifted;
`endif
      load = done && (!out_valid || out_ready);
      drop = done && out_valid && !out_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sreg         <= '0;
         cnt          <= '0;
         dir          <= 1'b0;
         parallel_out <= '0;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
         overrun      <= 1'b0;
`ifdef SIPO_DESERIALIZER_PARITY_EN
         parity_err   <= 1'b0;
`endif
      end else begin
         if (serial_valid) begin
            if (state == IDLE)
               dir <= lsb_first;
            if (shift_en)
               sreg <= shifted;
            if (done) begin
               cnt   <= '0;
               state <= IDLE;
               busy  <= 1'b0;
            end else begin
               cnt   <= cnt + 1'b1;
               state <= RECV;
               busy  <= 1'b1;
            end
         end

         // A completing word replaces a word being consumed on the same edge.
         if (load) begin
            parallel_out <= word;
            out_valid    <= 1'b1;
`ifdef SIPO_DESERIALIZER_PARITY_EN
            parity_err   <= perr;
`endif
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (drop)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: scoreboard of expected words, immediate-assertion checks.
module tb_sipo_deserializer;
   localparam int W = 8;
`ifdef SIPO_DESERIALIZER_PARITY_EN
   localparam int NB = W + 1;
`else
   localparam int NB = W;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         serial_in = 1'b0;
   logic         serial_valid = 1'b0;
   logic         lsb_first = 1'b0;
   logic         out_ready = 1'b0;
   logic         overrun_clr = 1'b0;
   logic [W-1:0] parallel_out;
   logic         out_valid;
   logic         busy;
   logic         overrun;
`ifdef SIPO_DESERIALIZER_PARITY_EN
   logic         parity_err;
`endif

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   sipo_deserializer #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .serial_in    (serial_in),
      .serial_valid (serial_valid),
      .lsb_first    (lsb_first),
      .out_ready    (out_ready),
      .overrun_clr  (overrun_clr),
      .parallel_out (parallel_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun)
`ifdef SIPO_DESERIALIZER_PARITY_EN
      ,
      .parity_err   (parity_err)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_word(input string tag);
      logic [W-1:0] e;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_data"}, 32'(parallel_out), 32'(e));
      end
   endtask

   task automatic consume();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("consume_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic send_word(input logic [W-1:0] d, input bit lsb, input int gap,
                            input bit rdy_last, input bit clr_last, input logic pbit);
      logic b;
      for (int i = 0; i < NB; i++) begin
         if (i < W) b = lsb ? d[i] : d[W-1-i];
         else       b = pbit;
         serial_in    = b;
         serial_valid = 1'b1;
         lsb_first    = (i == 0) ? lsb : 1'($urandom_range(0, 1));
         if (i == NB - 1) begin
            out_ready   = rdy_last;
            overrun_clr = clr_last;
         end
         step();
         serial_valid = 1'b0;
         out_ready    = 1'b0;
         overrun_clr  = 1'b0;
         chk("busy_bit", 32'(busy), (i < NB - 1) ? 32'd1 : 32'd0);
         if (i < NB - 1) begin
            for (int g = 0; g < gap; g++) begin
               step();
               chk("busy_gap", 32'(busy), 32'd1);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_data", 32'(parallel_out), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);

      exp_q.push_back(8'hA5);
      send_word(8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      expect_word("msb_a5");
      chk("msb_overrun", 32'(overrun), 32'd0);
      consume();

      exp_q.push_back(8'h3C);
      send_word(8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      expect_word("lsb_3c");
      consume();

      exp_q.push_back(8'h81);
      send_word(8'h81, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      expect_word("gap_81");
      consume();

      // 8'h22 completes while 8'h11 is still unconsumed and is dropped.
      exp_q.push_back(8'h11);
      send_word(8'h11, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b1, 0, 1'b0, 1'b0, 1'b1);
      expect_word("b2b_11");
      chk("b2b_overrun", 32'(overrun), 32'd1);
      overrun_clr = 1'b1;
      step();
      overrun_clr = 1'b0;
      chk("clr_overrun", 32'(overrun), 32'd0);
      chk("clr_valid", 32'(out_valid), 32'd1);
      chk("clr_data", 32'(parallel_out), 32'h11);

      exp_q.push_back(8'h33);
      send_word(8'h33, 1'b0, 0, 1'b1, 1'b0, 1'b0);
      expect_word("ready_on_done_33");
      chk("ready_on_done_overrun", 32'(overrun), 32'd0);

      send_word(8'h44, 1'b0, 0, 1'b0, 1'b1, 1'b1);
      chk("set_wins_overrun", 32'(overrun), 32'd1);
      chk("set_wins_data", 32'(parallel_out), 32'h33);

      // Partial word, then reset with a word pending and overrun set.
      for (int i = 0; i < 5; i++) begin
         serial_in    = 1'b1;
         serial_valid = 1'b1;
         lsb_first    = 1'b1;
         step();
      end
      serial_valid = 1'b0;
      chk("partial_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      chk("midrst_overrun", 32'(overrun), 32'd0);
      chk("midrst_data", 32'(parallel_out), 32'd0);
      exp_q.push_back(8'hF0);
      send_word(8'hF0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      expect_word("after_rst_f0");

`ifdef SIPO_DESERIALIZER_PARITY_EN
      consume();
      exp_q.push_back(8'h07);
      send_word(8'h07, 1'b0, 0, 1'b0, 1'b0, 1'b1);
      expect_word("par_good_07");
      chk("par_good_err", 32'(parity_err), 32'd0);
      consume();
      exp_q.push_back(8'h07);
      send_word(8'h07, 1'b1, 0, 1'b0, 1'b0, 1'b0);
      expect_word("par_bad_07");
      chk("par_bad_err", 32'(parity_err), 32'd1);
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sipo_deserializer.md
Name: sipo_deserializer

Overview:
- Serial-in/parallel-out receiver. It assembles a WIDTH-bit word from a qualified serial bit stream and presents it on a registered parallel output with a valid/ready handshake.
- It is the receiving end of the serial link driven by the team's universal shift register in shift-left or shift-right mode.
- The serial bit order is selectable per word, so it pairs with either shift direction of the transmitter.

Parameters:
- WIDTH, 8, number of data bits per word; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- serial_in  input  1  serial data bit.
- serial_valid  input  1  serial_in is a valid bit this cycle.
- lsb_first  input  1  0 = MSB arrives first (transmitter shifting left); 1 = LSB arrives first (shifting right). Sampled only on the first bit of a word.
- out_ready  input  1  consumer accepts parallel_out this cycle.
- overrun_clr  input  1  clears the overrun flag.
- parallel_out  output  WIDTH  assembled word; stable while out_valid=1.
- out_valid  output  1  parallel_out holds an unconsumed word.
- busy  output  1  a word is partially received (state RECV).
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (rst=1 at an edge) sets all outputs and internal state to 0: parallel_out=0, out_valid=0, busy=0, overrun=0, shift register 0, bit counter 0, state IDLE, latched direction 0. Reset overrides every other input, including mid-word; the partial word is discarded.
- State IDLE (cnt=0):
  - On serial_valid=1: latch dir=lsb_first, shift in the bit, set cnt=1, go to RECV.
  - With serial_valid=0: hold.
- State RECV (1 <= cnt <= WIDTH-1):
  - Each serial_valid=1 cycle shifts one bit and increments cnt.
  - serial_valid=0 holds all state; there are no gaps limit and no timeout.
  - lsb_first is ignored in RECV.
- Shift rule:
  - dir=0: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - dir=1: sreg <= {serial_in, sreg[WIDTH-1:1]}.
- Word completion: occurs on the edge where the WIDTH-th bit is accepted. On that edge cnt returns to 0 and the state returns to IDLE. The completed word is the shifted value including that bit.
- Output load:
  - The word is loaded into parallel_out, with out_valid=1, when out_valid=0 or out_ready=1 in that cycle.
  - Latency: out_valid rises on the same edge that accepts the last bit, i.e. visible the cycle after that bit was presented.
- Overrun:
  - If a word completes while out_valid=1 and out_ready=0, the word is dropped. parallel_out keeps the old word and overrun is set to 1.
- Handshake:
  - out_valid=1 with out_ready=1 consumes the word. out_valid goes to 0 next cycle unless a new word completes on that same edge, in which case the new word loads and out_valid stays 1.
  - out_ready with out_valid=0 has no effect.
- overrun_clr:
  - overrun_clr=1 clears overrun on the next edge.
  - If overrun_clr and a new drop coincide, overrun stays 1 (set wins).
- busy equals (state==RECV), registered.
- Back-to-back words: the first bit of the next word may arrive on the cycle immediately after completion. No dead cycle is allowed, so sustained throughput is 1 bit/clock.

Optional Feature:
- Macro: SIPO_DESERIALIZER_PARITY_EN.
- When defined:
  - Each word is WIDTH data bits followed by one even-parity bit, so completion occurs on the (WIDTH+1)-th bit. The parity bit is not shifted into sreg.
  - Adds output port parity_err (1 bit), which is loaded alongside parallel_out: 1 if XOR of data bits and parity bit is 1.
  - parity_err resets to 0 and is held while out_valid=1. A dropped word does not update it.
- When undefined: no parity bit and no parity_err port; the behaviour is exactly as above.

Test Plan:
- Reset then MSB-first: lsb_first=0, bits 1,0,1,0,0,1,0,1 on consecutive cycles with out_ready=0 -> out_valid=1 with parallel_out=8'hA5 after the 8th edge; busy=1 during bits 2-8 window, 0 after.
- LSB-first: lsb_first=1 on the first bit, then toggled randomly, bits of 8'h3C LSB first -> parallel_out=8'h3C (direction latched on bit 1 only).
- Gapped input: 8'h81 MSB-first with serial_valid=0 for 3 cycles between every bit -> parallel_out=8'h81, cnt/state held during gaps.
- Back-to-back plus overrun: send 8'h11 then 8'h22 with out_ready=0 -> parallel_out stays 8'h11 and overrun=1. Pulse overrun_clr -> overrun=0. Assert out_ready on the completion edge of 8'h33 -> out_valid stays 1 and parallel_out=8'h33.
- Reset mid-word: 5 bits, then rst=1 for one cycle -> busy=0, cnt=0, out_valid=0. The next 8 bits give a clean word 8'hF0.
- With PARITY_EN: 8'h07 plus parity bit 1 -> parity_err=0; 8'h07 plus parity bit 0 -> parity_err=1, completion on the 9th bit.
